// File: rtl/spi_shift_engine.sv
// ============================================================================
//  Module      : spi_shift_engine
//  Description : SPI master shift engine. Generates SCLK from a programmable
//                half-period, drives SS_N/MOSI, samples MISO and reports one
//                completed frame per accepted start request.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_shift_engine #(
    parameter int DW = 8
) (
    input  logic          BCLK,
    input  logic          RST,
    input  logic          en,
    input  logic          cpol,
    input  logic          cpha,
    input  logic          lsbfe,
    input  logic [2:0]    sppr,
    input  logic [2:0]    spr,
    input  logic          start,
    input  logic [DW-1:0] tx_data,
    input  logic          MISO,
    output logic          SCLK,
    output logic          MOSI,
    output logic          SS_N,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] rx_data
);

    // Edge counter must hold 0..2*DW
    localparam int EW = $clog2(2 * DW + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEAD  = 2'd1,
        XFER  = 2'd2,
        TRAIL = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [10:0]     cnt_q, cnt_d;
    logic [10:0]     hm1_q, hm1_d;
    logic [EW-1:0]   edge_q, edge_d;
    logic            sclk_q, sclk_d;
    logic            mosi_q, mosi_d;
    logic            done_q, done_d;
    logic            cpol_q, cpol_d;
    logic            cpha_q, cpha_d;
    logic            lsbfe_q, lsbfe_d;
    logic [DW-1:0]   tx_sr_q, tx_sr_d;
    logic [DW-1:0]   rx_sr_q, rx_sr_d;
    logic [DW-1:0]   rx_data_q, rx_data_d;

    logic [10:0]     w_h;
    logic            w_tick;
    logic [EW-1:0]   w_k;
    logic            w_lead;
    logic            w_last;
    logic [DW-1:0]   w_tx_shift;
    logic [DW-1:0]   w_rx_in;
    logic [DW-1:0]   w_ntx;

    // State register and all datapath registers
    always_ff @(posedge BCLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hm1_q     <= '0;
            edge_q    <= '0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            done_q    <= 1'b0;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            lsbfe_q   <= 1'b0;
            tx_sr_q   <= '0;
            rx_sr_q   <= '0;
            rx_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hm1_q     <= hm1_d;
            edge_q    <= edge_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            done_q    <= done_d;
            cpol_q    <= cpol_d;
            cpha_q    <= cpha_d;
            lsbfe_q   <= lsbfe_d;
            tx_sr_q   <= tx_sr_d;
            rx_sr_q   <= rx_sr_d;
            rx_data_q <= rx_data_d;
        end
    end

    // Next-state logic: half-period timing, edge sequencing, shifting, abort
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hm1_d      = hm1_q;
        edge_d     = edge_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        done_d     = 1'b0;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        lsbfe_d    = lsbfe_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        rx_data_d  = rx_data_q;
        w_ntx      = tx_sr_q;

        // H = (sppr+1) * 2^spr, range 1..1024
        w_h        = {7'd0, 4'({1'b0, sppr} + 4'd1)} << spr;
        w_tick     = (cnt_q == 11'd0);
        w_k        = edge_q + EW'(1);
        w_lead     = w_k[0];
        w_last     = (w_k == EW'(2 * DW));
        w_tx_shift = lsbfe_q ? (tx_sr_q >> 1) : (tx_sr_q << 1);
        w_rx_in    = lsbfe_q ? {MISO, rx_sr_q[DW-1:1]} : {rx_sr_q[DW-2:0], MISO};

        case (state_q)
            IDLE: begin
                // A start coinciding with done is still part of the old frame
                if (start && en && !done_q) begin
                    state_d = LEAD;
                    cpol_d  = cpol;
                    cpha_d  = cpha;
                    lsbfe_d = lsbfe;
                    hm1_d   = w_h - 11'd1;
                    cnt_d   = w_h - 11'd1;
                    edge_d  = '0;
                    sclk_d  = cpol;
                    tx_sr_d = tx_data;
                    rx_sr_d = '0;
                    mosi_d  = cpha ? 1'b0 : (lsbfe ? tx_data[0] : tx_data[DW-1]);
                end
            end
            LEAD, XFER: begin
                if (w_tick) begin
                    cnt_d   = hm1_q;
                    edge_d  = w_k;
                    sclk_d  = ~sclk_q;
                    state_d = w_last ? TRAIL : XFER;
                    if (cpha_q) begin
                        // Leading edges launch data (first one without shifting)
                        if (w_lead) begin
                            w_ntx   = (w_k == EW'(1)) ? tx_sr_q : w_tx_shift;
                            tx_sr_d = w_ntx;
                            mosi_d  = lsbfe_q ? w_ntx[0] : w_ntx[DW-1];
                        end else begin
                            rx_sr_d = w_rx_in;
                        end
                    end else begin
                        // First bit was launched at acceptance; last trailing edge launches nothing
                        if (w_lead) begin
                            rx_sr_d = w_rx_in;
                        end else if (!w_last) begin
                            tx_sr_d = w_tx_shift;
                            mosi_d  = lsbfe_q ? w_tx_shift[0] : w_tx_shift[DW-1];
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 11'd1;
                end
            end
            TRAIL: begin
                if (w_tick) begin
                    state_d   = IDLE;
                    done_d    = 1'b1;
                    rx_data_d = rx_sr_q;
                    mosi_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q - 11'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Disabling the engine abandons the frame without completion
        if (state_q != IDLE && !en) begin
            state_d   = IDLE;
            done_d    = 1'b0;
            rx_data_d = rx_data_q;
            mosi_d    = 1'b0;
            sclk_d    = cpol_q;
        end
    end

    // In IDLE SCLK tracks the live polarity; it is held low while in reset
    assign SCLK    = (state_q == IDLE) ? (cpol & RST) : sclk_q;
    assign MOSI    = (state_q == IDLE) ? 1'b0 : mosi_q;
    assign SS_N    = (state_q == IDLE);
    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign rx_data = rx_data_q;

endmodule

`default_nettype wire
